riscv_instr_encoder: RTL and testbench
======================================

// Module: riscv_instr_encoder
// PURPOSE
//  Instruction encoder/loader: converse of the control main decoder. Accepts decoded fields
//  (opcode, rd, rs1, rs2, funct3, funct7, imm) over valid/ready and packs them into RV32I words by format.
//  Streams the words into instruction memory through an auto-incrementing write port.
//  Used by the boot/test loader to fill imem before the core leaves reset.
// PARAMETERS
//  ADDR_W     10            word-address width of the imem write port
//  BASE_ADDR  0             word address loaded into the address counter on istart
//  NOP_INSTR  32'h00000013  word emitted for illegal requests (addi x0,x0,0)
// PORTS
//  iclk      in   1   clock, rising edge
//  irst      in   1   reset, asynchronous, active-high
//  istart    in   1   begin load session (sampled in IDLE only)
//  ivalid    in   1   upstream field bundle valid
//  oready    out  1   upstream ready (encoder can accept)
//  ilast     in   1   bundle is last of session (qualified by ivalid&&oready)
//  iop       in   7   opcode
//  ird       in   5   destination register
//  irs1      in   5   source register 1
//  irs2      in   5   source register 2
//  ifunct3   in   3   funct3
//  ifunct7   in   7   funct7 (R-type only)
//  iimm      in   32  immediate, byte offset / full value, sign already applied
//  ovalid    out  1   encoded word valid (also imem write enable when iready=1)
//  iready    in   1   imem/downstream ready
//  oinstr    out  32  encoded instruction
//  oaddr     out  ADDR_W  imem word address of oinstr
//  oillegal  out  1   oinstr replaced by NOP_INSTR (unknown opcode or misaligned B/J imm)
//  ocount    out  ADDR_W+1  words transferred in current session
//  odone     out  1   one-cycle pulse after last word transferred
// BEHAVIOUR
//  Reset: FSM=IDLE; oready=0, ovalid=0, oinstr=0, oaddr=BASE_ADDR, oillegal=0, ocount=0, odone=0.
//  FSM IDLE: oready=0; istart -> LOAD, oaddr<=BASE_ADDR, ocount<=0.
//  FSM LOAD: oready = !ovalid || iready (single output register, no bubble under full throughput).
//    - Input xfer (ivalid&&oready): oinstr/oillegal/last_q registered, ovalid<=1; latency 1 cycle.
//    - Output xfer (ovalid&&iready): oaddr<=oaddr+1 (wraps mod 2^ADDR_W), ocount+=1;
//      ovalid<=0 unless a new input xfer occurs in the same cycle (then stays 1, new word loaded).
//    - Output xfer with last_q=1 -> DONE; no further input accepted after a last input xfer.
//    - istart ignored in LOAD and DONE.
//  FSM DONE: odone=1 for exactly one cycle, ovalid=0 -> IDLE; oaddr/ocount hold until next istart.
//  Hold: while ovalid && !iready, oinstr/oaddr/oillegal stable.
//  Encoding (opcode selects format):
//    R  0x33: funct7|rs2|rs1|f3|rd|op
//    I  0x03,0x13,0x67: imm[11:0]|rs1|f3|rd|op
//    S  0x23: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//    B  0x63: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
//    U  0x37,0x17: imm[31:12]|rd|op
//    J  0x6F: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
//  Unused fields ignored; immediate bits outside the format's field are truncated, not flagged.
//  Illegal: any other opcode, or B/J with iimm[0]=1 -> oinstr=NOP_INSTR, oillegal=1; still written.
//  Async reset mid-session: immediate return to IDLE, any held word dropped, odone not pulsed.
// TESTING
//  istart; addi x1,x0,5 (op13,rd1,f3 0,imm5), iready=1 -> oinstr=0x00500093, oaddr=0, 1-cycle latency
//  add x3,x1,x2 (op33,f7 0) then sw x2,8(x1) (op23,f3 2) -> 0x002081B3 @0, 0x0020A423 @1, back-to-back
//  lui x5,0x12345000 -> 0x123452B7; jal x1,8 -> 0x008000EF; jal imm=7 -> 0x00000013, oillegal=1
//  iready=0 for 3 cycles with ovalid=1 -> oready=0, oinstr/oaddr stable; resume -> no loss/duplicate
//  BASE_ADDR=2^ADDR_W-1, 2 words -> oaddr goes max then 0; ocount=2; odone pulses 1 cycle after last
//  irst asserted mid-session with ovalid=1 -> all outputs reset values same cycle, odone stays 0

Source files
------------

// File: rtl/riscv_instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them into imem.
// One output register; a new bundle can be taken in the cycle the held word leaves.
module riscv_instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int          BASE_ADDR = 0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              ivalid,
    output logic              oready,
    input  logic              ilast,
    input  logic [6:0]        iop,
    input  logic [4:0]        ird,
    input  logic [4:0]        irs1,
    input  logic [4:0]        irs2,
    input  logic [2:0]        ifunct3,
    input  logic [6:0]        ifunct7,
    input  logic [31:0]       iimm,
    output logic              ovalid,
    input  logic              iready,
    output logic [31:0]       oinstr,
    output logic [ADDR_W-1:0] oaddr,
    output logic              oillegal,
    output logic [ADDR_W:0]   ocount,
    output logic              odone,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t      state;
    logic        last_q;
    logic        last_in;
    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        in_xfer;
    logic        out_xfer;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Upstream is held off once the last bundle of a session has been taken.
    assign oready    = (state == LOAD) && !last_in && (!ovalid || iready);
    assign in_xfer   = ivalid && oready;
    assign out_xfer  = ovalid && iready;
    assign dbg_state = state;

    always_comb begin
        enc_instr   = NOP_INSTR;
        enc_illegal = 1'b0;
        case (iop)
            7'h33: enc_instr = {ifunct7, irs2, irs1, ifunct3, ird, iop};
            7'h03, 7'h13, 7'h67: enc_instr = {iimm[11:0], irs1, ifunct3, ird, iop};
            7'h23: enc_instr = {iimm[11:5], irs2, irs1, ifunct3, iimm[4:0], iop};
            7'h63: begin
                if (iimm[0]) begin
                    enc_illegal = 1'b1;
                end else begin
                    enc_instr = {iimm[12], iimm[10:5], irs2, irs1, ifunct3,
                                 iimm[4:1], iimm[11], iop};
                end
            end
            7'h37, 7'h17: enc_instr = {iimm[31:12], ird, iop};
            7'h6F: begin
                if (iimm[0]) begin
                    enc_illegal = 1'b1;
                end else begin
                    enc_instr = {iimm[20], iimm[10:1], iimm[11], iimm[19:12], ird, iop};
                end
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= IDLE;
            ovalid   <= 1'b0;
            oinstr   <= 32'h0;
            oaddr    <= BASE;
            oillegal <= 1'b0;
            ocount   <= '0;
            odone    <= 1'b0;
            last_q   <= 1'b0;
            last_in  <= 1'b0;
        end else begin
            odone <= 1'b0;
            case (state)
                IDLE: begin
                    if (istart) begin
                        state   <= LOAD;
                        oaddr   <= BASE;
                        ocount  <= '0;
                        last_q  <= 1'b0;
                        last_in <= 1'b0;
                    end
                end
                LOAD: begin
                    if (out_xfer) begin
                        oaddr  <= oaddr + ADDR_ONE;
                        ocount <= ocount + CNT_ONE;
                        ovalid <= 1'b0;
                        if (last_q) begin
                            state <= DONE;
                            odone <= 1'b1;
                        end
                    end
                    // A word accepted in the same cycle overrides the ovalid clear above.
                    if (in_xfer) begin
                        oinstr   <= enc_instr;
                        oillegal <= enc_illegal;
                        last_q   <= ilast;
                        last_in  <= ilast;
                        ovalid   <= 1'b1;
                    end
                end
                DONE: begin
                    ovalid <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed bench for riscv_instr_encoder: expected words go to a queue on input
// transfer and are checked when the encoder hands them to imem.
module tb_riscv_instr_encoder;

    logic        iclk;
    logic        irst;
    logic        istart;
    logic        istart2;
    logic        ivalid;
    logic        ilast;
    logic [6:0]  iop;
    logic [4:0]  ird;
    logic [4:0]  irs1;
    logic [4:0]  irs2;
    logic [2:0]  ifunct3;
    logic [6:0]  ifunct7;
    logic [31:0] iimm;
    logic        iready;

    logic        oready, ovalid, oillegal, odone;
    logic [31:0] oinstr;
    logic [9:0]  oaddr;
    logic [10:0] ocount;
    logic [1:0]  dbg_state;

    logic        oready2, ovalid2, oillegal2, odone2;
    logic [31:0] oinstr2;
    logic [3:0]  oaddr2;
    logic [4:0]  ocount2;
    logic [1:0]  dbg_state2;

    int total = 0;
    int bad   = 0;
    logic [42:0] exp_q[$];
    logic [9:0]  exp_addr;

    riscv_instr_encoder dut (
        .iclk(iclk), .irst(irst), .istart(istart), .ivalid(ivalid), .oready(oready),
        .ilast(ilast), .iop(iop), .ird(ird), .irs1(irs1), .irs2(irs2),
        .ifunct3(ifunct3), .ifunct7(ifunct7), .iimm(iimm), .ovalid(ovalid),
        .iready(iready), .oinstr(oinstr), .oaddr(oaddr), .oillegal(oillegal),
        .ocount(ocount), .odone(odone), .dbg_state(dbg_state)
    );

    riscv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(15)) dut_wrap (
        .iclk(iclk), .irst(irst), .istart(istart2), .ivalid(ivalid), .oready(oready2),
        .ilast(ilast), .iop(iop), .ird(ird), .irs1(irs1), .irs2(irs2),
        .ifunct3(ifunct3), .ifunct7(ifunct7), .iimm(iimm), .ovalid(ovalid2),
        .iready(iready), .oinstr(oinstr2), .oaddr(oaddr2), .oillegal(oillegal2),
        .ocount(ocount2), .odone(odone2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: every word handed to imem must match the head of the queue
    always @(negedge iclk) begin
        if (!irst && ovalid && iready) begin
            logic [42:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", {oillegal, oaddr, oinstr});
            end else begin
                e = exp_q.pop_front();
                assert ({oillegal, oaddr, oinstr} === e) else begin
                    bad++;
                    $error("FAIL sb_word observed=%h expected=%h", {oillegal, oaddr, oinstr}, e);
                end
            end
        end
    end

    // driver tasks: all entered and left at posedge+1
    task automatic start_session();
        istart = 1'b1;
        @(posedge iclk); #1;
        istart   = 1'b0;
        exp_addr = 10'd0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_instr, input logic exp_ill, input logic track);
        int n;
        iop = op; ird = rd; irs1 = rs1; irs2 = rs2; ifunct3 = f3; ifunct7 = f7; iimm = imm;
        ilast  = last;
        ivalid = 1'b1;
        n = 0;
        @(negedge iclk);
        while (!oready && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("send_accept", {63'd0, oready}, 64'd1);
        if (track) begin
            exp_q.push_back({exp_ill, exp_addr, exp_instr});
            exp_addr++;
        end
        @(posedge iclk); #1;
        ivalid = 1'b0;
        ilast  = 1'b0;
    endtask

    task automatic wait_done(input logic [10:0] exp_cnt, input logic [9:0] exp_end_addr);
        int n;
        n = 0;
        @(negedge iclk);
        while (!odone && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("done_seen", {63'd0, odone}, 64'd1);
        chk("done_count", {53'd0, ocount}, {53'd0, exp_cnt});
        chk("done_addr", {54'd0, oaddr}, {54'd0, exp_end_addr});
        chk("done_ovalid", {63'd0, ovalid}, 64'd0);
        @(negedge iclk);
        chk("done_pulse_1cyc", {63'd0, odone}, 64'd0);
        chk("done_state_idle", {62'd0, dbg_state}, 64'd0);
        chk("done_count_hold", {53'd0, ocount}, {53'd0, exp_cnt});
        @(posedge iclk); #1;
    endtask

    initial begin
        irst = 1'b1; istart = 1'b0; istart2 = 1'b0; ivalid = 1'b0; ilast = 1'b0;
        iop = '0; ird = '0; irs1 = '0; irs2 = '0; ifunct3 = '0; ifunct7 = '0; iimm = '0;
        iready = 1'b1; exp_addr = '0;
        repeat (2) @(negedge iclk);
        chk("rst_oready", {63'd0, oready}, 64'd0);
        chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("rst_oinstr", {32'd0, oinstr}, 64'd0);
        chk("rst_oaddr", {54'd0, oaddr}, 64'd0);
        chk("rst_oillegal", {63'd0, oillegal}, 64'd0);
        chk("rst_ocount", {53'd0, ocount}, 64'd0);
        chk("rst_odone", {63'd0, odone}, 64'd0);
        chk("rst_oaddr_wrap", {60'd0, oaddr2}, 64'd15);
        @(posedge iclk); #1;
        irst = 1'b0;
        @(posedge iclk); #1;
        chk("idle_oready", {63'd0, oready}, 64'd0);

        // session 1: addi x1,x0,5 with 1-cycle latency
        start_session();
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0, 1'b1);
        chk("lat_ovalid", {63'd0, ovalid}, 64'd1);
        chk("lat_oinstr", {32'd0, oinstr}, 64'h0050_0093);
        wait_done(11'd1, 10'd1);

        // session 2: add then sw, back-to-back
        start_session();
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0020_81B3, 1'b0, 1'b1);
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020_A423, 1'b0, 1'b1);
        wait_done(11'd2, 10'd2);

        // session 3: U/J/B formats, illegal cases, stall with stray istart
        start_session();
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7, 1'b0, 1'b1);
        iready = 1'b0;
        istart = 1'b1;
        @(posedge iclk); #1;
        istart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iclk);
            chk("stall_oready", {63'd0, oready}, 64'd0);
            chk("stall_ovalid", {63'd0, ovalid}, 64'd1);
            chk("stall_oinstr", {32'd0, oinstr}, 64'h1234_52B7);
            chk("stall_oaddr", {54'd0, oaddr}, 64'd0);
        end
        @(posedge iclk); #1;
        iready = 1'b1;
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'h0080_00EF, 1'b0, 1'b1);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd16, 1'b0, 32'h0020_9863, 1'b0, 1'b1);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3, 1'b0, 1'b1);
        send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
        wait_done(11'd7, 10'd7);

        // session 4: async reset while a word is held
        start_session();
        iready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0, 1'b0);
        @(negedge iclk);
        chk("pre_rst_ovalid", {63'd0, ovalid}, 64'd1);
        #1 irst = 1'b1;
        #1;
        chk("mid_rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("mid_rst_oinstr", {32'd0, oinstr}, 64'd0);
        chk("mid_rst_oaddr", {54'd0, oaddr}, 64'd0);
        chk("mid_rst_ocount", {53'd0, ocount}, 64'd0);
        chk("mid_rst_oready", {63'd0, oready}, 64'd0);
        chk("mid_rst_state", {62'd0, dbg_state}, 64'd0);
        @(posedge iclk); #1;
        irst   = 1'b0;
        iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iclk);
            chk("post_rst_odone", {63'd0, odone}, 64'd0);
            chk("post_rst_ovalid", {63'd0, ovalid}, 64'd0);
        end
        @(posedge iclk); #1;

        // address wrap: 4-bit port starting at 15
        istart2 = 1'b1;
        @(posedge iclk); #1;
        istart2 = 1'b0;
        iop = 7'h13; ird = 5'd1; irs1 = 5'd0; ifunct3 = 3'd0; iimm = 32'd5;
        ilast = 1'b0; ivalid = 1'b1;
        @(negedge iclk);
        chk("wrap_oready", {63'd0, oready2}, 64'd1);
        @(posedge iclk); #1;
        iop = 7'h33; ird = 5'd3; irs1 = 5'd1; irs2 = 5'd2; ifunct7 = 7'd0; iimm = 32'd0;
        ilast = 1'b1;
        @(negedge iclk);
        chk("wrap_w0_ovalid", {63'd0, ovalid2}, 64'd1);
        chk("wrap_w0_addr", {60'd0, oaddr2}, 64'd15);
        chk("wrap_w0_instr", {32'd0, oinstr2}, 64'h0050_0093);
        @(posedge iclk); #1;
        ivalid = 1'b0; ilast = 1'b0;
        @(negedge iclk);
        chk("wrap_w1_ovalid", {63'd0, ovalid2}, 64'd1);
        chk("wrap_w1_addr", {60'd0, oaddr2}, 64'd0);
        chk("wrap_w1_instr", {32'd0, oinstr2}, 64'h0020_81B3);
        chk("wrap_w1_count", {59'd0, ocount2}, 64'd1);
        @(negedge iclk);
        chk("wrap_odone", {63'd0, odone2}, 64'd1);
        chk("wrap_count", {59'd0, ocount2}, 64'd2);
        chk("wrap_end_addr", {60'd0, oaddr2}, 64'd1);
        @(negedge iclk);
        chk("wrap_odone_1cyc", {63'd0, odone2}, 64'd0);

        chk("sb_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
